lf_prefix_adder32: RTL and testbench

- Registered 32-lane inclusive prefix population count, built as a Ladner-Fischer parallel-prefix tree.
- Each output lane i carries the number of set bits in mask[i:0].
- Used by the redundancy controller to compute compaction/slot indices from a 32-bit occupancy mask.
- Single clock domain; one register stage at the output.

---
 rtl/lf_prefix_adder32.sv | 78 +++++++
 tb/tb_lf_prefix_adder32.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lf_prefix_adder32.sv
// lf_prefix_adder32
//   Registered 32-lane inclusive prefix population count. Lane i of psum
//   holds the number of set bits in mask[i:0], computed by a Ladner-Fischer
//   parallel-prefix tree (5 combine levels) followed by one output register.
//   The redundancy controller uses the lanes as compaction/slot indices.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears psum and out_valid
//   in_valid   qualifies mask on the current edge
//   mask       32 occupancy bits, bit 0 is lane 0
//   out_valid  psum was computed from a valid mask (in_valid delayed 1 cycle)
//   psum       192 bits, lane i at psum[6*i +: 6], unsigned 0..i+1
module lf_prefix_adder32 (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [31:0]  mask,
  output logic         out_valid,
  output logic [191:0] psum
);

  localparam int LANES = 32;
  localparam int CW    = 6;

  // One Ladner-Fischer combine level. Every lane whose index has bit l set
  // adds the prefix held by the last lane of the preceding 2^l block; the
  // other lanes pass through. Lanes are carried at the full 6 bits; at level
  // l no lane exceeds 2^(l+1), so the upper bits are constant zero and are
  // trimmed by synthesis, giving the 1..6-bit width growth of the tree.
  function automatic logic [LANES*CW-1:0] lf_level(input logic [LANES*CW-1:0] p,
                                                   input int l);
    logic [LANES*CW-1:0] r;
    int src;
    r = p;
    for (int i = 0; i < LANES; i++) begin
      if (((i >> l) & 1) != 0) begin
        // Last lane of the block just below lane i at this level.
        src = ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
        r[CW*i +: CW] = p[CW*i +: CW] + p[CW*src +: CW];
      end
    end
    return r;
  endfunction

  logic [LANES*CW-1:0] lvl0, lvl1, lvl2, lvl3, lvl4, lvl5;

  // Level 0: each lane starts as its own occupancy bit, zero-extended.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first so no path leaves it unassigned, which would infer a latch.
    lvl0 = '0;
    for (int i = 0; i < LANES; i++) begin
      lvl0[CW*i +: CW] = {5'b0, mask[i]};
    end
  end

  assign lvl1 = lf_level(lvl0, 0);
  assign lvl2 = lf_level(lvl1, 1);
  assign lvl3 = lf_level(lvl2, 2);
  assign lvl4 = lf_level(lvl3, 3);
  assign lvl5 = lf_level(lvl4, 4);

  // psum reloads every cycle regardless of in_valid; consumers qualify it
  // with out_valid. Reset dominates, discarding whatever was in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      psum      <= '0;
      out_valid <= 1'b0;
    end else begin
      psum      <= lvl5;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_lf_prefix_adder32.sv
// Testbench for lf_prefix_adder32. A driver applies one input set per cycle
// on the falling edge and pushes the expected registered response into a
// scoreboard queue; an independent monitor samples 1 time unit after each
// rising edge, pops one entry and compares out_valid and psum.
module tb_lf_prefix_adder32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [31:0]  mask;
  logic         out_valid;
  logic [191:0] psum;

  always #5 clk = ~clk;

  lf_prefix_adder32 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .mask      (mask),
    .out_valid (out_valid),
    .psum      (psum)
  );

  typedef struct {
    logic         valid;
    logic [191:0] psum;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Golden model: straightforward per-lane count of mask[i:0].
  function automatic logic [191:0] golden(input logic [31:0] m);
    logic [191:0] e;
    int cnt;
    e = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = 0;
      for (int k = 0; k <= i; k++) cnt += int'(m[k]);
      e[6*i +: 6] = cnt[5:0];
    end
    return e;
  endfunction

  // Hand-derived lanes for mask bits {0,1,4,13,19,27}.
  function automatic logic [191:0] exp_mixed();
    logic [191:0] e;
    int v;
    e = '0;
    for (int i = 0; i < 32; i++) begin
      if      (i == 0) v = 1;
      else if (i < 4)  v = 2;
      else if (i < 13) v = 3;
      else if (i < 19) v = 4;
      else if (i < 27) v = 5;
      else             v = 6;
      e[6*i +: 6] = v[5:0];
    end
    return e;
  endfunction

  // All ones: lane i = i+1.
  function automatic logic [191:0] exp_ones();
    logic [191:0] e;
    int v;
    for (int i = 0; i < 32; i++) begin
      v = i + 1;
      e[6*i +: 6] = v[5:0];
    end
    return e;
  endfunction

  // 0x55555555: lane i = floor(i/2)+1.
  function automatic logic [191:0] exp_alt();
    logic [191:0] e;
    int v;
    for (int i = 0; i < 32; i++) begin
      v = i / 2 + 1;
      e[6*i +: 6] = v[5:0];
    end
    return e;
  endfunction

  // 0x80000000: only lane 31 is 1.
  function automatic logic [191:0] exp_top();
    logic [191:0] e;
    e = '0;
    e[186 +: 6] = 6'd1;
    return e;
  endfunction

  // Apply one cycle of stimulus and record the response expected after the
  // next rising edge.
  task automatic drive(input logic r, input logic v, input logic [31:0] m,
                       input logic [191:0] e, input string name);
    exp_t x;
    reset    = r;
    in_valid = v;
    mask     = m;
    x.valid  = r ? 1'b0 : v;
    x.psum   = r ? '0 : e;
    x.name   = name;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [191:0] got,
                       input logic [191:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge while stimulus is queued.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check({x.name, " out_valid"}, {191'b0, out_valid}, {191'b0, x.valid});
        check({x.name, " psum"}, psum, x.psum);
      end
    end
  end

  initial begin
    logic [31:0] m;
    logic        v;
    int          waited;

    // Reset with an all-ones mask present, then release with the same mask.
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, '0,         "reset");
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, exp_ones(), "all_ones");
    drive(1'b0, 1'b1, 32'h0000_0000, '0,         "all_zero");
    drive(1'b0, 1'b1, 32'b00001000000010000010000000010011, exp_mixed(), "mixed");
    // Back-to-back distinct results.
    drive(1'b0, 1'b1, 32'h8000_0000, exp_top(), "top_bit");
    drive(1'b0, 1'b1, 32'h5555_5555, exp_alt(), "alternating");
    // Stable mask: psum keeps updating with in_valid low and stays constant.
    drive(1'b0, 1'b0, 32'h5555_5555, exp_alt(), "hold_invalid");
    drive(1'b0, 1'b1, 32'h5555_5555, exp_alt(), "hold_valid");

    // Random stream with toggling in_valid and a mid-stream reset pulse.
    for (int n = 0; n < 40; n++) begin
      m = $urandom;
      v = 1'($urandom_range(0, 1));
      if (n == 20) drive(1'b1, v, m, '0, "rand_reset");
      else         drive(1'b0, v, m, golden(m), "rand");
    end
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, golden(32'hFFFF_FFFF), "post_rand");

    // Bounded drain of the scoreboard.
    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
